// File: rtl/cam_pkg.sv
// Shared helpers for the content-addressable memory.
// Size limits, safe clog2 and a population count.
package cam_pkg;

  localparam int MAX_DEPTH = 256;
  localparam int MAX_CW    = 9;

  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_CW-1:0] popcount(
    input logic [MAX_DEPTH-1:0] v
  );
    logic [MAX_CW-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_DEPTH; i++)
      c = c + MAX_CW'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder with any / multi flags.
// Shared by the match path and the free-slot search.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDXW  = 4
) (
  input  logic [DEPTH-1:0] req,
  output logic             any,
  output logic [IDXW-1:0]  idx,
  output logic             multi
);

  always_comb begin
    any   = 1'b0;
    idx   = '0;
    multi = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (req[i]) begin
        if (any) begin
          multi = 1'b1;
        end else begin
          any = 1'b1;
          idx = IDXW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/cam_array.sv
// CAM with per-entry valid/mask, explicit/auto writes,
// invalidate, and a registered one-cycle search result.
module cam_array
  import cam_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int TERNARY = 0,
  parameter int IDXW    = clog2_safe(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             writeEn_i,
  input  logic             wr_auto_i,
  input  logic [IDXW-1:0]  wr_idx_i,
  input  logic [WIDTH-1:0] writedat_i,
  input  logic [WIDTH-1:0] wrmask_i,
  input  logic             inval_i,
  input  logic [IDXW-1:0]  inval_idx_i,
  input  logic             search_i,
  input  logic [WIDTH-1:0] searchn_i,
  output logic             wr_ack_o,
  output logic [IDXW-1:0]  wr_idx_o,
  output logic             full_o,
  output logic [IDXW:0]    count_o,
  output logic             match_valid_o,
  output logic             match_o,
  output logic [IDXW-1:0]  match_idx_o,
  output logic             multi_o
);

  localparam int CW = IDXW + 1;

  typedef struct packed {
    logic            hit;
    logic [IDXW-1:0] idx;
    logic            multi;
  } match_res_t;

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_nx;
  logic [DEPTH-1:0] hit_vec;
  logic [DEPTH-1:0] wr_sel;
  logic [DEPTH-1:0] inv_sel;

  logic [WIDTH-1:0] mask_in;
  logic             in_range;
  logic             wr_go;
  logic [IDXW-1:0]  wr_tgt;
  logic [CW-1:0]    cnt_nx;

  logic             h_any;
  logic [IDXW-1:0]  h_idx;
  logic             h_multi;
  logic             f_any;
  logic [IDXW-1:0]  f_idx;
  logic             free_multi_unused;

  match_res_t       hit_res;
  match_res_t       res_q;

  // Constant-zero mask storage folds away when not ternary.
  assign mask_in  = (TERNARY != 0) ? wrmask_i : '0;
  assign in_range = int'(wr_idx_i) < DEPTH;

  assign wr_go  = writeEn_i & (wr_auto_i ? f_any : in_range);
  assign wr_tgt = wr_auto_i ? f_idx : wr_idx_i;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [WIDTH-1:0] dat_q;
    logic [WIDTH-1:0] msk_q;

    always_ff @(posedge clk) begin
      if (wr_sel[i]) begin
        dat_q <= writedat_i;
        msk_q <= mask_in;
      end
    end

    assign wr_sel[i]  = wr_go & (wr_tgt == IDXW'(i));
    assign inv_sel[i] = inval_i & (inval_idx_i == IDXW'(i));
    assign hit_vec[i] = valid[i] &
      ~|((dat_q ^ searchn_i) & ~msk_q);
  end

  // Write is applied after invalidate, so it wins on a tie.
  assign valid_nx = (valid & ~inv_sel) | wr_sel;
  assign cnt_nx   = CW'(popcount(MAX_DEPTH'(valid_nx)));

  cam_prio_enc #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_hit_enc (
    .req   (hit_vec),
    .any   (h_any),
    .idx   (h_idx),
    .multi (h_multi)
  );

  cam_prio_enc #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_free_enc (
    .req   (~valid),
    .any   (f_any),
    .idx   (f_idx),
    .multi (free_multi_unused)
  );

  assign hit_res = '{hit: h_any, idx: h_idx, multi: h_multi};

  always_ff @(posedge clk) begin
    if (rst) begin
      valid         <= '0;
      count_o       <= '0;
      full_o        <= 1'b0;
      wr_ack_o      <= 1'b0;
      wr_idx_o      <= '0;
      match_valid_o <= 1'b0;
      res_q         <= '0;
    end else begin
      valid         <= valid_nx;
      count_o       <= cnt_nx;
      full_o        <= cnt_nx == CW'(DEPTH);
      wr_ack_o      <= wr_go;
      if (wr_go)
        wr_idx_o    <= wr_tgt;
      match_valid_o <= search_i;
      res_q         <= search_i ? hit_res : '0;
    end
  end

  assign match_o     = res_q.hit;
  assign match_idx_o = res_q.idx;
  assign multi_o     = res_q.multi;

endmodule

// File: tb/tb_cam_array.sv
// Directed plus random stimulus for cam_array against an
// array/queue reference model kept in the bench.
module tb_cam_array;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       writeEn_i = 1'b0;
  logic       wr_auto_i = 1'b0;
  logic [3:0] wr_idx_i = '0;
  logic [7:0] writedat_i = '0;
  logic [7:0] wrmask_i = '0;
  logic       inval_i = 1'b0;
  logic [3:0] inval_idx_i = '0;
  logic       search_i = 1'b0;
  logic [7:0] searchn_i = '0;
  logic       wr_ack_o;
  logic [3:0] wr_idx_o;
  logic       full_o;
  logic [4:0] count_o;
  logic       match_valid_o;
  logic       match_o;
  logic [3:0] match_idx_o;
  logic       multi_o;

  int total = 0;
  int bad   = 0;

  bit       mv [16];
  bit [7:0] md [16];
  bit [7:0] mm [16];
  int       e_widx = 0;

  cam_array #(
    .WIDTH   (8),
    .DEPTH   (16),
    .TERNARY (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .writeEn_i     (writeEn_i),
    .wr_auto_i     (wr_auto_i),
    .wr_idx_i      (wr_idx_i),
    .writedat_i    (writedat_i),
    .wrmask_i      (wrmask_i),
    .inval_i       (inval_i),
    .inval_idx_i   (inval_idx_i),
    .search_i      (search_i),
    .searchn_i     (searchn_i),
    .wr_ack_o      (wr_ack_o),
    .wr_idx_o      (wr_idx_o),
    .full_o        (full_o),
    .count_o       (count_o),
    .match_valid_o (match_valid_o),
    .match_o       (match_o),
    .match_idx_o   (match_idx_o),
    .multi_o       (multi_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, we, wa,
                      input bit [3:0] wi,
                      input bit [7:0] wd, wm,
                      input bit iv,
                      input bit [3:0] ii,
                      input bit s,
                      input bit [7:0] sk);
    int q[$];
    int tgt;
    int cnt;
    bit ack;
    rst = r;
    writeEn_i = we;
    wr_auto_i = wa;
    wr_idx_i = wi;
    writedat_i = wd;
    wrmask_i = wm;
    inval_i = iv;
    inval_idx_i = ii;
    search_i = s;
    searchn_i = sk;
    @(posedge clk);
    ack = 0;
    tgt = -1;
    if (r) begin
      foreach (mv[i]) mv[i] = 0;
      e_widx = 0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (mv[i] && ((md[i] ^ sk) & ~mm[i]) == 8'h00)
          q.push_back(i);
      if (we) begin
        if (wa) begin
          for (int i = 15; i >= 0; i--)
            if (!mv[i]) tgt = i;
        end else begin
          tgt = int'(wi);
        end
        ack = (tgt >= 0);
      end
      if (iv) mv[ii] = 0;
      if (ack) begin
        mv[tgt] = 1;
        md[tgt] = wd;
        mm[tgt] = wm;
        e_widx = tgt;
      end
    end
    cnt = 0;
    foreach (mv[i]) cnt += int'(mv[i]);
    #1;
    chk("wr_ack", wr_ack_o, ack);
    chk("count", count_o, cnt);
    chk("full", full_o, cnt == 16);
    chk("match_valid", match_valid_o, s && !r);
    if (r || we)
      chk("wr_idx", wr_idx_o, e_widx);
    if (r || s) begin
      chk("match", match_o, q.size() > 0);
      chk("match_idx", match_idx_o,
          (q.size() > 0) ? q[0] : 0);
      chk("multi", multi_o, q.size() > 1);
    end
  endtask

  task automatic rs();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input bit [3:0] i, input bit [7:0] k,
                    input bit [7:0] m);
    step(0, 1, 0, i, k, m, 0, 0, 0, 0);
  endtask

  task automatic aw(input bit [7:0] k);
    step(0, 1, 1, 0, k, 0, 0, 0, 0, 0);
  endtask

  task automatic srch(input bit [7:0] k);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, k);
  endtask

  task automatic inv(input bit [3:0] i);
    step(0, 0, 0, 0, 0, 0, 1, i, 0, 0);
  endtask

  initial begin
    rs();
    rs();
    chk("rst_count", count_o, 0);

    wr(5, 8'h3A, 8'h00);
    srch(8'h3A);
    chk("t1_hit", match_o, 1);
    chk("t1_idx", match_idx_o, 5);
    chk("t1_count", count_o, 1);

    rs();
    for (int k = 0; k < 16; k++) begin
      aw(8'(k * 7 + 1));
      chk("auto_idx", wr_idx_o, k);
    end
    chk("auto_full", full_o, 1);
    aw(8'hEE);
    chk("auto_drop_ack", wr_ack_o, 0);
    chk("auto_drop_cnt", count_o, 16);
    chk("auto_drop_idx", wr_idx_o, 15);

    rs();
    wr(3, 8'h11, 8'h00);
    wr(9, 8'h11, 8'h00);
    srch(8'h11);
    chk("dup_idx", match_idx_o, 3);
    chk("dup_multi", multi_o, 1);
    inv(3);
    srch(8'h11);
    chk("inv_idx", match_idx_o, 9);
    chk("inv_multi", multi_o, 0);
    chk("inv_count", count_o, 1);

    step(0, 1, 0, 2, 8'h55, 8'h00, 0, 0, 1, 8'h55);
    chk("rbw_miss", match_o, 0);
    srch(8'h55);
    chk("rbw_hit", match_o, 1);
    chk("rbw_idx", match_idx_o, 2);

    wr(7, 8'hA0, 8'h0F);
    srch(8'hA7);
    chk("tern_hit", match_o, 1);
    srch(8'hB0);
    chk("tern_miss", match_o, 0);
    wr(12, 8'h00, 8'hFF);
    srch(8'h5C);
    chk("wild_idx", match_idx_o, 12);

    step(0, 1, 0, 4, 8'h66, 8'h00, 1, 4, 0, 0);
    step(0, 1, 1, 0, 8'h77, 8'h00, 1, 9, 0, 0);
    inv(9);
    inv(9);

    srch(8'h11);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 8'h11);
    chk("mid_rst_mv", match_valid_o, 0);
    chk("mid_rst_cnt", count_o, 0);
    srch(8'h11);
    chk("post_rst_miss", match_o, 0);
    srch(8'hA7);
    chk("post_rst_wild", match_o, 0);

    for (int n = 0; n < 600; n++) begin
      step(($urandom % 60) == 0,
           1'($urandom), 1'($urandom),
           4'($urandom), 8'($urandom % 12),
           (($urandom % 4) == 0) ? 8'($urandom % 4) : 8'h00,
           ($urandom % 3) == 0, 4'($urandom),
           1'($urandom), 8'($urandom % 12));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
